// File: rtl/point_decoder_pkg.sv
// Shared constants and types for the Koblitz point decoder.
package point_decoder_pkg;

  // Datapath width of Mx/My and of the decoded message.
  localparam int DATAWIDTH = 16;

  // Default Koblitz expansion factor.
  localparam logic [DATAWIDTH-1:0] KOBLITZ_K_DEFAULT = DATAWIDTH'(20);

  // Handshake FSM encodings.
  typedef enum logic [1:0] {
    DEC_S_IDLE   = 2'd0,
    DEC_S_DIVIDE = 2'd1,
    DEC_S_DONE   = 2'd2
  } dec_state_t;

  // Decoded result as presented on the output side.
  typedef struct packed {
    logic [DATAWIDTH-1:0] msg;
    logic [DATAWIDTH-1:0] j;
  } dec_rsp_t;

endpackage

// File: rtl/point_decoder_serial_divider.sv
// Serial restoring divider by a constant: one quotient bit per clock.
// start loads the dividend; done is high during the final iteration cycle,
// so quotient/remainder are complete right after that edge and held until
// the next start.
module point_decoder_serial_divider #(
  parameter int             W       = 16,
  parameter logic [W-1:0]   DIVISOR = W'(1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W:0]   remainder
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  dvd_q;
  logic [W:0]    rem_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [W:0]    rem_sh;
  logic [W:0]    rem_nxt;
  logic          qbit;

  // One restoring step: shift in the dividend MSB, subtract if it fits.
  // The remainder is always < DIVISOR, so W bits plus the shifted-in bit
  // never overflow W+1 bits.
  always_comb begin
    rem_sh  = {rem_q[W-1:0], dvd_q[W-1]};
    qbit    = (rem_sh >= {1'b0, DIVISOR});
    rem_nxt = qbit ? (rem_sh - {1'b0, DIVISOR}) : rem_sh;
  end

  // Dividend register doubles as the quotient register: bits shift out
  // at the MSB and quotient bits enter at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      dvd_q  <= dividend_in;
      rem_q  <= '0;
      cnt_q  <= CW'(W-1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      dvd_q <= {dvd_q[W-2:0], qbit};
      rem_q <= rem_nxt;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - CW'(1);
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == '0);
  assign quotient  = dvd_q;
  assign remainder = rem_q;

endmodule

// File: rtl/point_decoder.sv
// Koblitz point decoder: msg = floor(Mx/K), j = Mx mod K.
// Valid/ready on both sides; one serial divide per point.
// Optional feature macro: DECODE_ERR_EN adds err_out, flagging the
// point at infinity (Mx==0 && My==0) and zeroing msg/j for it.
module point_decoder
  import point_decoder_pkg::*;
#(
  parameter logic [DATAWIDTH-1:0] KOBLITZ_K = KOBLITZ_K_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] Mx_in,
  input  logic [DATAWIDTH-1:0] My_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] msg_out,
  output logic [DATAWIDTH-1:0] j_out
`ifdef DECODE_ERR_EN
  ,
  output logic                 err_out
`endif
);

  // K = 0 has no meaning for Koblitz decoding; stop elaboration.
  if (KOBLITZ_K == '0) begin : g_bad_k
    $error("point_decoder: KOBLITZ_K must be >= 1");
  end

  dec_state_t           state_q, state_d;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 accept;
  logic                 zero_rsp;
  logic                 div_busy;
  logic                 div_done;
  logic [DATAWIDTH-1:0] div_quo;
  logic [DATAWIDTH:0]   div_rem;
  dec_rsp_t             rsp;
  logic                 unused_bits;

  assign accept = in_valid && in_ready_q;

  point_decoder_serial_divider #(
    .W       (DATAWIDTH),
    .DIVISOR (KOBLITZ_K)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (accept),
    .dividend_in (Mx_in),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_quo),
    .remainder   (div_rem)
  );

  // Next-state logic for the IDLE -> DIVIDE -> DONE -> IDLE handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DEC_S_IDLE:   if (accept)    state_d = DEC_S_DIVIDE;
      DEC_S_DIVIDE: if (div_done)  state_d = DEC_S_DONE;
      DEC_S_DONE:   if (out_ready) state_d = DEC_S_IDLE;
      default:                     state_d = DEC_S_IDLE;
    endcase
  end

  // State plus registered handshake outputs, decoded from the next state
  // so neither ready nor valid has a combinational input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DEC_S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == DEC_S_IDLE);
      out_valid_q <= (state_d == DEC_S_DONE);
    end
  end

`ifdef DECODE_ERR_EN
  logic err_q;

  // Capture the infinity encoding alongside the dividend at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= (Mx_in == '0) && (My_in == '0);
  end

  assign err_out     = out_valid_q && err_q;
  assign zero_rsp    = err_q;
  assign unused_bits = ^{div_busy, div_rem[DATAWIDTH]};
`else
  assign zero_rsp    = 1'b0;
  assign unused_bits = ^{div_busy, div_rem[DATAWIDTH], My_in};
`endif

  // Result is shown only in DONE; the divider holds it until the next start.
  always_comb begin
    rsp = '0;
    if (out_valid_q && !zero_rsp) begin
      rsp.msg = div_quo;
      rsp.j   = div_rem[DATAWIDTH-1:0];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign msg_out   = rsp.msg;
  assign j_out     = rsp.j;

endmodule

// File: tb/tb_point_decoder.sv
// Directed bench for point_decoder (DATAWIDTH=16, K=20).
module tb_point_decoder;
  import point_decoder_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] Mx_in;
  logic [DATAWIDTH-1:0] My_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] msg_out;
  logic [DATAWIDTH-1:0] j_out;
`ifdef DECODE_ERR_EN
  logic                 err_out;
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  point_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Mx_in     (Mx_in),
    .My_in     (My_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .msg_out   (msg_out),
    .j_out     (j_out)
`ifdef DECODE_ERR_EN
    ,
    .err_out   (err_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [15:0] mx;
    logic [15:0] my;
    logic [15:0] msg;
    logic [15:0] j;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; counts edges until out_valid is seen at a negedge.
  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
  endtask

  // Full transaction with out_ready=1: accept, latency, result, handshake.
  task automatic run_point(input vec_t v, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; Mx_in = v.mx; My_in = v.my;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    wait_out(tag, n);
    chk({tag, "_latency"}, 32'(n), 32'd16);
    chk({tag, "_msg"}, 32'(msg_out), 32'(v.msg));
    chk({tag, "_j"}, 32'(j_out), 32'(v.j));
`ifdef DECODE_ERR_EN
    chk({tag, "_err"}, 32'(err_out), 32'(v.err));
`endif
    chk({tag, "_ready_done"}, 32'(in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    int idx, r, last_cyc, cyc;
    logic [15:0] pts[4];

    rst_n = 1'b0; in_valid = 1'b0; Mx_in = '0; My_in = '0; out_ready = 1'b1;

    //          mx         my      msg        j       err
    vecs[0] = '{16'd1043,  16'd7,  16'd52,    16'd3,  1'b0};
    vecs[1] = '{16'd19,    16'd1,  16'd0,     16'd19, 1'b0};
    vecs[2] = '{16'd65535, 16'd9,  16'd3276,  16'd15, 1'b0};
    vecs[3] = '{16'd0,     16'd5,  16'd0,     16'd0,  1'b0};
    vecs[4] = '{16'd0,     16'd0,  16'd0,     16'd0,  ERR_ON};
    vecs[5] = '{16'd20,    16'd0,  16'd1,     16'd0,  1'b0};
    vecs[6] = '{16'd39,    16'd2,  16'd1,     16'd19, 1'b0};
    vecs[7] = '{16'd400,   16'd3,  16'd20,    16'd0,  1'b0};
    vecs[8] = '{16'd12345, 16'd4,  16'd617,   16'd5,  1'b0};
    vecs[9] = '{16'd1,     16'd0,  16'd0,     16'd1,  1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_msg", 32'(msg_out), 32'd0);
    chk("rst_j", 32'(j_out), 32'd0);
`ifdef DECODE_ERR_EN
    chk("rst_err", 32'(err_out), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_point(vecs[i], $sformatf("vec%0d", i));

    // Backpressure with a pending input held through DONE
    out_ready = 1'b0;
    in_valid = 1'b1; Mx_in = 16'd1043; My_in = 16'd1;
    @(posedge clk); @(negedge clk);
    Mx_in = 16'd400;
    wait_out("bp", n);
    chk("bp_latency", 32'(n), 32'd16);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_hold%0d", c), {out_valid, in_ready, msg_out[7:0], j_out[7:0]},
          {1'b1, 1'b0, 8'd52, 8'd3});
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_handshake_ready", 32'(in_ready), 32'd1);
    chk("bp_handshake_valid", 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("bp_pending_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_out("bp2", n);
    chk("bp2_latency", 32'(n), 32'd16);
    chk("bp2_msg", 32'(msg_out), 32'd20);
    chk("bp2_j", 32'(j_out), 32'd0);
    @(posedge clk); @(negedge clk);

    // Asynchronous reset in the middle of a divide
    in_valid = 1'b1; Mx_in = 16'd1043;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_msg", 32'(msg_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen++;
    end
    chk("arst_no_result", 32'(seen), 32'd0);
    run_point(vecs[7], "post_rst");

    // Back-to-back: in_valid held high, results spaced by 18 cycles
    for (int i = 0; i < 4; i++) pts[i] = 16'($urandom);
    idx = 0; r = 0; last_cyc = 0; cyc = 0;
    in_valid = 1'b1;
    while (r < 4 && cyc < 300) begin
      if (out_valid) begin
        chk($sformatf("b2b%0d_msg", r), 32'(msg_out), 32'(pts[r] / 16'd20));
        chk($sformatf("b2b%0d_j", r), 32'(j_out), 32'(pts[r] % 16'd20));
        if (r > 0) chk($sformatf("b2b%0d_spacing", r), 32'(cyc - last_cyc), 32'd18);
        last_cyc = cyc;
        r++;
      end
      if (in_ready && idx < 4) begin
        Mx_in = pts[idx];
        idx++;
      end else if (!in_ready && idx == 4) begin
        in_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    chk("b2b_count", 32'(r), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
